vga_port_arbiter: RTL and testbench
===================================

Name: vga_port_arbiter

Overview:
- Clocked arbiter sharing the single VGA framebuffer port between two requesters: requester 0 (motherboard/CPU path) and requester 1 (scanout/refresh engine).
- Runs the full 4-phase ctrl/ack handshake on the VGA side: strobe, ack high, release, ack low.
- Gives each requester a simple req/done/err interface.
- Sits between the motherboard state machine and the VGA device, replacing direct drive of vga_ctrl.

Parameters:
- word_width, `WORD_WIDTH (32): width of addr, data, ctrl and stat words.
- timeout_cycles, 1024: maximum cycles spent in STROBE or RELEASE before abort.
- cnt_width, 11: width of the timeout counter; must hold timeout_cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request level; held until done/err is seen.
- we0, we1  in  1  1=write, 0=read; valid while reqN is high.
- addr0, addr1  in  word_width  target address.
- wdata0, wdata1  in  word_width  write data.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  one-cycle timeout pulse.
- rdata  out  word_width  read data, valid on the done cycle and held until the next read completes.
- vga_ctrl  out  word_width  only bits VGA_WRITE_PIN and VGA_READ_PIN are driven; all other bits are 0.
- vga_stat  in  word_width  only bit VGA_ACK is used.
- vga_addr, vga_wdata  out  word_width  registered; stable for the whole transaction.
- vga_rdata  in  word_width  device read data.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Reset has priority over everything, including mid-transaction.
- Reset values:
  - state=IDLE; all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - timeout counter=0.
- A reset mid-transaction drops vga_ctrl on the next edge. No done/err is issued for the killed transaction.
- IDLE:
  - Arbitration happens only when vga_stat[VGA_ACK]==0 and at least one reqN is high.
  - A single requester is granted.
  - If both request, grant the requester other than last_grant (round-robin). Update last_grant.
  - Latch owner, we, addr, wdata into registers. Go to STROBE.
- STROBE:
  - vga_ctrl[VGA_WRITE_PIN]=we_q and vga_ctrl[VGA_READ_PIN]=!we_q, asserted from the first STROBE cycle.
  - When ack==1 is sampled:
    - vga_ctrl goes to 0 on the next edge.
    - For a read, vga_rdata is captured into rdata on that same edge.
    - Go to RELEASE.
- RELEASE: hold vga_ctrl=0. When ack==0 is sampled, go to DONE.
- DONE:
  - Assert done[owner] for exactly one cycle, then go to IDLE.
  - req inputs are ignored in DONE, so a registered requester can drop req before IDLE re-samples it.
- Latency: with an immediate device, req high at edge 0 gives ctrl asserted in cycle 1.
  - ack seen at cycle k: ctrl low in cycle k+1.
  - ack low seen at cycle m: done in cycle m+1.
  - Minimum is 4 cycles request-to-done.
- Timeout:
  - The counter clears on entry to STROBE and to RELEASE, and increments each cycle while in either state.
  - When it reaches timeout_cycles-1 without the awaited ack level:
    - err[owner] pulses for one cycle in place of done.
    - vga_ctrl is forced to 0.
    - state returns to IDLE. IDLE will not issue until ack is low.
- Stray ack: ack high in IDLE blocks grants; no error is raised.
- Requester drop: a requester dropping req mid-transaction does not abort it; done is still pulsed.
- Registering: vga_addr and vga_wdata are registered from the latched request and are not mux-through combinational.
- Single bus: never both ctrl pins high; never more than one transaction outstanding.

Decomposition:
- Shared package/defines:
  - VGA_WRITE_PIN=0, VGA_READ_PIN=1, VGA_ACK=0.
  - State encodings IDLE/STROBE/RELEASE/DONE.
  - WORD_WIDTH.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant from req0/req1/last_grant, combinational, with last_grant register in the parent).

Test Plan:
1. Single write: req0, we0=1, addr0=0x0000_1234, wdata0=0xDEAD_BEEF, device acks 2 cycles after strobe and drops ack 1 cycle after release -> vga_ctrl=0x1 with addr/wdata held during STROBE; done0 pulses once; err0=0.
2. Single read: req1, addr1=0x40, device returns vga_rdata=0x0000_00A5 with ack -> ctrl=0x2; rdata=0xA5 on the done1 cycle and held afterwards.
3. Contention: req0 and req1 high together from reset, each re-requesting after done -> grant order 0,1,0,1; no overlapping strobes.
4. Timeout: device never acks, timeout_cycles=16 -> err0 pulses in cycle 17 after the STROBE entry; ctrl=0; next request is granted normally.
5. Stuck ack: ack held high in IDLE with req0 high -> no strobe until ack falls, then the grant proceeds.
6. Reset mid-STROBE: assert rst in the second STROBE cycle -> next cycle vga_ctrl=0, state IDLE, no done/err pulse.

Source files
------------

// File: rtl/vga_port_arbiter_pkg.sv
// Shared constants for the VGA framebuffer port arbiter: word width, ctrl/stat bit positions, FSM encodings.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package vga_port_arbiter_pkg;
    localparam int WORD_WIDTH    = `WORD_WIDTH;

    localparam int VGA_WRITE_PIN = 0;
    localparam int VGA_READ_PIN  = 1;
    localparam int VGA_ACK       = 0;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;
endpackage

// File: rtl/vga_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester that did not win last time gets the port.
// Latency: combinational; the last_grant register lives in the parent.
// Backpressure: none, grant is only meaningful when the parent is ready to accept it.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_vld,
    output logic gnt_id
);
    assign gnt_vld = req0 | req1;
    assign gnt_id  = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/vga_port_arbiter.sv
// Shares the single VGA framebuffer port between the CPU path (0) and scanout (1) using the 4-phase ctrl/ack handshake.
// Latency: grant edge -> strobe next cycle; minimum 4 cycles request-to-done with an immediate device.
// Backpressure: requesters hold req until done/err; no grant while ack is still high from a previous cycle.
module vga_port_arbiter
    import vga_port_arbiter_pkg::*;
#(
    parameter int word_width     = WORD_WIDTH,
    parameter int timeout_cycles = 1024,
    parameter int cnt_width      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [word_width-1:0] addr0,
    input  logic [word_width-1:0] addr1,
    input  logic [word_width-1:0] wdata0,
    input  logic [word_width-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [word_width-1:0] rdata,
    output logic [word_width-1:0] vga_ctrl,
    input  logic [word_width-1:0] vga_stat,
    output logic [word_width-1:0] vga_addr,
    output logic [word_width-1:0] vga_wdata,
    input  logic [word_width-1:0] vga_rdata
);
    localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(timeout_cycles - 1);

    state_t               state_q;
    logic                 last_grant_q;
    logic                 owner_q;
    logic                 we_q;
    logic [cnt_width-1:0] cnt_q;
    logic                 ctrl_wr_q;
    logic                 ctrl_rd_q;
    logic [1:0]           err_q;

    logic ack;
    logic gnt_vld;
    logic gnt_id;
    logic timed_out;
    logic sel_we;
    logic unused_stat;

    assign ack         = vga_stat[VGA_ACK];
    assign unused_stat = ^vga_stat[word_width-1:1];
    assign timed_out   = (cnt_q == CNT_LAST);
    assign sel_we      = gnt_id ? we1 : we0;

    rr_arbiter2 u_rr_arbiter2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            ctrl_wr_q    <= 1'b0;
            ctrl_rd_q    <= 1'b0;
            err_q        <= '0;
            rdata        <= '0;
            vga_addr     <= '0;
            vga_wdata    <= '0;
        end else begin
            err_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    // A stray ack left high by the device keeps the port closed.
                    if (!ack && gnt_vld) begin
                        owner_q      <= gnt_id;
                        last_grant_q <= gnt_id;
                        we_q         <= sel_we;
                        vga_addr     <= gnt_id ? addr1 : addr0;
                        vga_wdata    <= gnt_id ? wdata1 : wdata0;
                        ctrl_wr_q    <= sel_we;
                        ctrl_rd_q    <= ~sel_we;
                        cnt_q        <= '0;
                        state_q      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (ack) begin
                        ctrl_wr_q <= 1'b0;
                        ctrl_rd_q <= 1'b0;
                        if (!we_q) begin
                            rdata <= vga_rdata;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end else if (timed_out) begin
                        ctrl_wr_q       <= 1'b0;
                        ctrl_rd_q       <= 1'b0;
                        err_q[owner_q]  <= 1'b1;
                        state_q         <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!ack) begin
                        state_q <= ST_DONE;
                    end else if (timed_out) begin
                        err_q[owner_q] <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // DONE ignores req so the owner can drop it before IDLE samples again.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vga_ctrl                = '0;
        vga_ctrl[VGA_WRITE_PIN] = ctrl_wr_q;
        vga_ctrl[VGA_READ_PIN]  = ctrl_rd_q;
    end

    assign done0 = (state_q == ST_DONE) && !owner_q;
    assign done1 = (state_q == ST_DONE) &&  owner_q;
    assign err0  = err_q[0];
    assign err1  = err_q[1];
endmodule

// File: tb/tb_vga_port_arbiter.sv
// Randomised bench for vga_port_arbiter: behavioural device + requester agents checked against a rule-level model.
module tb_vga_port_arbiter;
    import vga_port_arbiter_pkg::*;

    localparam int TMO = 16;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata, vga_ctrl, vga_addr, vga_wdata;
    logic [31:0] vga_stat = '0;
    logic [31:0] vga_rdata = '0;

    vga_port_arbiter #(
        .word_width     (32),
        .timeout_cycles (TMO),
        .cnt_width      (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .rdata     (rdata),
        .vga_ctrl  (vga_ctrl),
        .vga_stat  (vga_stat),
        .vga_addr  (vga_addr),
        .vga_wdata (vga_wdata),
        .vga_rdata (vga_rdata)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int err_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Device: 0 = normal, 1 = never acks, 2 = ack stuck high
    int dev_mode = 0, ack_dly = 0, rel_dly = 0, dcnt = 0;
    bit dev_rand = 0;
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        vga_stat[31:1] = 31'($urandom);
        if (dev_mode == 2) begin
            vga_stat[VGA_ACK] = 1'b1;
        end else if (vga_ctrl[1:0] != 2'b00 && !vga_stat[VGA_ACK]) begin
            if (dev_mode == 0 && dcnt >= ack_dly) begin
                vga_stat[VGA_ACK] = 1'b1;
                dcnt = 0;
                if (vga_ctrl[VGA_READ_PIN])
                    vga_rdata = dev_mem.exists(vga_addr) ? dev_mem[vga_addr] : dflt(vga_addr);
                else
                    dev_mem[vga_addr] = vga_wdata;
                if (dev_rand) rel_dly = $urandom_range(0, 3);
            end else begin
                dcnt++;
            end
        end else if (vga_ctrl[1:0] == 2'b00 && vga_stat[VGA_ACK]) begin
            if (dcnt >= rel_dly) begin
                vga_stat[VGA_ACK] = 1'b0;
                dcnt = 0;
                if (dev_rand) ack_dly = $urandom_range(0, 3);
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    // Requester queues and model state
    txn_t        q0[$], q1[$];
    int          done_order[$];
    bit          gap = 0;
    int          cyc = 0, slen = 0, rlen = 0, strobe_cyc = 0, err0_cyc = 0;
    int          n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, n_strobes = 0;
    bit          rel = 0, blk = 0;
    logic        ref_last = 1'b1, cur_own = 1'b0;
    logic [31:0] ref_rd = '0, p_ctrl = '0, act_prev_ctrl = '0, first_ctrl = '0;
    txn_t        cur = '0;

    task automatic tick();
        logic        a_s, rq0, rq1, rst_s;
        logic [31:0] exp_ctrl;
        logic [1:0]  exp_done, exp_err;
        @(posedge clk);
        #1;
        cyc++;
        a_s = vga_stat[VGA_ACK];
        rq0 = req0;
        rq1 = req1;
        rst_s = rst;
        exp_ctrl = '0;
        exp_done = '0;
        exp_err  = '0;
        if (rst_s) begin
            rel = 0; blk = 0; ref_last = 1'b1; ref_rd = '0;
        end else if (p_ctrl != 0) begin
            slen++;
            if (a_s) begin
                rel = 1; rlen = 0;
                if (cur.we) ref_mem[cur.addr] = cur.wdata;
                else ref_rd = ref_read(cur.addr);
            end else if (slen == TMO) begin
                exp_err[cur_own] = 1'b1;
            end else begin
                exp_ctrl = p_ctrl;
            end
        end else if (rel) begin
            rlen++;
            if (!a_s) begin
                exp_done[cur_own] = 1'b1; rel = 0; blk = 1;
            end else if (rlen == TMO) begin
                exp_err[cur_own] = 1'b1; rel = 0;
            end
        end else if (blk) begin
            blk = 0;
        end else if (!a_s && (rq0 || rq1)) begin
            // Round robin: a lone requester wins; on a tie the one not served last wins.
            cur_own  = (rq0 && rq1) ? !ref_last : rq1;
            ref_last = cur_own;
            if (cur_own) cur = (q1.size() != 0) ? q1[0] : txn_t'(0);
            else         cur = (q0.size() != 0) ? q0[0] : txn_t'(0);
            exp_ctrl   = cur.we ? 32'h1 : 32'h2;
            slen       = 0;
            strobe_cyc = cyc;
        end
        check("ctrl", vga_ctrl, exp_ctrl);
        check("done", 32'({done1, done0}), 32'(exp_done));
        check("err", 32'({err1, err0}), 32'(exp_err));
        check("rdata", rdata, ref_rd);
        if (exp_ctrl != 0) begin
            check("vga_addr", vga_addr, cur.addr);
            check("vga_wdata", vga_wdata, cur.wdata);
        end
        p_ctrl = exp_ctrl;

        if (vga_ctrl != 0 && act_prev_ctrl == 0) begin
            n_strobes++;
            first_ctrl = vga_ctrl;
        end
        act_prev_ctrl = vga_ctrl;

        if (done0 || err0) begin
            if (done0) begin n_done0++; done_order.push_back(0); end
            if (err0) begin n_err0++; err0_cyc = cyc; end
            if (q0.size() != 0) q0.delete(0);
            req0 = 1'b0;
        end else if (!req0 && q0.size() != 0 && (!gap || $urandom_range(0, 3) != 0)) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
        end
        if (done1 || err1) begin
            if (done1) begin n_done1++; done_order.push_back(1); end
            if (err1) n_err1++;
            if (q1.size() != 0) q1.delete(0);
            req1 = 1'b0;
        end else if (!req1 && q1.size() != 0 && (!gap || $urandom_range(0, 3) != 0)) begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || req0 || req1) && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int d0, d1, e0, s0, n, p0, p1;
        repeat (3) tick();
        check("rst_ctrl", vga_ctrl, 32'h0);
        check("rst_addr", vga_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Single write, device acks 2 cycles into the strobe and releases 1 cycle late
        ack_dly = 2; rel_dly = 1;
        q0.push_back('{1'b1, 32'h0000_1234, 32'hDEAD_BEEF});
        drain("t1", 100);
        check("t1_ctrl", first_ctrl, 32'h1);
        check("t1_done0", 32'(n_done0), 32'd1);
        check("t1_err0", 32'(n_err0), 32'd0);

        // Single read on requester 1
        ack_dly = 0; rel_dly = 0;
        dev_mem[32'h40] = 32'h0000_00A5;
        ref_mem[32'h40] = 32'h0000_00A5;
        q1.push_back('{1'b0, 32'h0000_0040, 32'h0});
        drain("t2", 100);
        check("t2_ctrl", first_ctrl, 32'h2);
        check("t2_done1", 32'(n_done1), 32'd1);
        check("t2_rdata_held", rdata, 32'h0000_00A5);

        // Contention from reset: grant order must alternate starting with 0
        do_reset();
        done_order.delete();
        q0.push_back('{1'b1, 32'h100, 32'h1111_0000});
        q0.push_back('{1'b0, 32'h104, 32'h0});
        q1.push_back('{1'b1, 32'h200, 32'h2222_0000});
        q1.push_back('{1'b0, 32'h100, 32'h0});
        drain("t3", 200);
        check("t3_count", 32'(done_order.size()), 32'd4);
        for (int i = 0; i < done_order.size() && i < 4; i++)
            check("t3_order", 32'(done_order[i]), 32'(i % 2));

        // Timeout: device never acks
        dev_mode = 1;
        e0 = n_err0; d0 = n_done0;
        q0.push_back('{1'b1, 32'h300, 32'hCAFE_0001});
        n = 0;
        while (n_err0 == e0 && n < 60) begin tick(); n++; end
        check("t4_err0", 32'(n_err0 - e0), 32'd1);
        check("t4_err_latency", 32'(err0_cyc - strobe_cyc), 32'(TMO));
        dev_mode = 0;
        q0.push_back('{1'b1, 32'h304, 32'hCAFE_0002});
        drain("t4", 100);
        check("t4_recovered", 32'(n_done0 - d0), 32'd1);

        // Stuck ack in IDLE blocks the grant until it falls
        dev_mode = 2; ack_dly = 0; rel_dly = 0;
        tick();
        s0 = n_strobes; d0 = n_done0;
        q0.push_back('{1'b0, 32'h104, 32'h0});
        repeat (8) tick();
        check("t5_nogrant", 32'(n_strobes - s0), 32'd0);
        dev_mode = 0;
        drain("t5", 100);
        check("t5_strobes", 32'(n_strobes - s0), 32'd1);
        check("t5_done0", 32'(n_done0 - d0), 32'd1);

        // Reset in the second STROBE cycle kills the transaction silently
        dev_mode = 1;
        d0 = n_done0; e0 = n_err0;
        q0.push_back('{1'b0, 32'h80, 32'h0});
        n = 0;
        while (vga_ctrl == 0 && n < 20) begin tick(); n++; end
        check("t6_strobe_seen", vga_ctrl, 32'h2);
        tick();
        rst = 1'b1; q0.delete(); req0 = 1'b0;
        tick();
        check("t6_ctrl_after_rst", vga_ctrl, 32'h0);
        rst = 1'b0; dev_mode = 0;
        repeat (6) tick();
        check("t6_no_pulse", 32'((n_done0 - d0) + (n_err0 - e0)), 32'd0);

        // Randomised mixed traffic with random device timing and request gaps
        dev_rand = 1; gap = 1;
        p0 = 0; p1 = 0;
        d0 = n_done0; d1 = n_done1; e0 = n_err0 + n_err1;
        for (int i = 0; i < 48; i++) begin
            txn_t t;
            t.we    = 1'($urandom);
            t.addr  = 32'($urandom_range(0, 7)) << 2;
            t.wdata = $urandom;
            if ($urandom_range(0, 1) == 0) begin q0.push_back(t); p0++; end
            else begin q1.push_back(t); p1++; end
        end
        drain("t7", 4000);
        check("t7_done0", 32'(n_done0 - d0), 32'(p0));
        check("t7_done1", 32'(n_done1 - d1), 32'(p1));
        check("t7_errs", 32'(n_err0 + n_err1 - e0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end
endmodule
